mc6809_dma_arbiter: RTL and testbench
=====================================

# mc6809_dma_arbiter

Bus-sharing controller for the MC6809 core. It takes DMA bus requests from up to NREQ external masters, drives the core's nDMABREQ, and waits for the core to release the bus (BA=1, BS=1). It then grants the bus to one requester at a time in round-robin order and caps each burst so the core gets its refresh cycle. All decisions are made at bus-cycle boundaries, marked by the core's E-fall clock-enable strobe.

## Interface
- NREQ, 4: number of DMA requesters (2..8).
- MAX_BURST, 14: maximum bus cycles per grant (1..15).
- CLK  in  1  system clock; same root clock that feeds the CPU core.
- nRESET  in  1  asynchronous, active-low reset.
- CE_E_FALL  in  1  one-CLK-wide pulse at each E falling edge (bus-cycle boundary).
- REQ  in  NREQ  level request per master; sampled only when CE_E_FALL=1.
- BA  in  1  bus available, from core.
- BS  in  1  bus status, from core.
- nDMABREQ  out  1  to core; low requests the bus.
- GNT  out  NREQ  one-hot grant; at most one bit set.
- OWNER  out  clog2(NREQ)  index of current or last granted master.
- BUSY  out  1  high whenever state is not IDLE.

## Operation
- Single posedge-CLK domain. State, counters and outputs update only on edges where CE_E_FALL=1. nRESET is the only exception.
- States: IDLE, WAIT_BA, GRANT, RELEASE.
- IDLE: nDMABREQ=1, GNT=0. If any REQ bit is set, pick the winner by round-robin search starting at (last+1) mod NREQ. Latch the winner into OWNER, drive nDMABREQ=0 and go to WAIT_BA.
- WAIT_BA:
  - If REQ[OWNER]=0, abort: nDMABREQ=1, go to RELEASE. `last` is not updated.
  - Else if BA=1 and BS=1, set GNT[OWNER]=1, set burst_cnt=0 and go to GRANT.
  - Withdrawal takes priority over BA.
- GRANT: each boundary increments burst_cnt. The burst ends if REQ[OWNER]=0 or burst_cnt==MAX_BURST-1 (the grant has lasted MAX_BURST cycles). On burst end:
  - GNT=0 and nDMABREQ=1 on the same edge;
  - last=OWNER;
  - go to RELEASE.
- RELEASE: hold nDMABREQ=1 and GNT=0. When BA=0 is seen at a boundary, go to IDLE. A new arbitration cannot happen before the following boundary, so the core always gets at least one owned cycle between bursts.
- Round robin: `last` is updated only at the end of a completed grant. It resets to NREQ-1, so master 0 has first priority after reset.
- burst_cnt is 4 bits and never wraps, because the terminal test fires at MAX_BURST-1.
- REQ changes between boundaries are ignored. Only the value sampled at a boundary counts.

## Timing
- Reset (asynchronous, immediate):
  - nDMABREQ=1, GNT=0, BUSY=0, OWNER=0;
  - state=IDLE, burst_cnt=0, last=NREQ-1.
- Reset in the middle of a grant drops GNT and releases nDMABREQ with no clock. The core regains the bus through its own reset.
- REQ to nDMABREQ low: 1 boundary (registered at the first boundary where REQ is seen).
- nDMABREQ low to GNT: the first boundary that samples BA=BS=1, plus 0 extra cycles. The core's dead cycle is absorbed by waiting for BA.
- Grant length: at most MAX_BURST boundaries from GNT rising to GNT falling. GNT and nDMABREQ deassert on the same edge.
- Simultaneous REQ from several masters at one boundary: only the round-robin winner is served. The others wait at least one full RELEASE→IDLE round trip.
- BA held high externally (e.g. by nHALT) while in RELEASE: stay in RELEASE until BA=0. There is no timeout.
- CE_E_FALL asserted on consecutive CLKs: each one is a boundary. This is not expected from the clock generator, but it must not corrupt state.

## Test plan
- NREQ=4, MAX_BURST=14. Single master:
  - Stimulus: REQ=0001; BA/BS go high 2 boundaries after nDMABREQ falls.
  - Required: nDMABREQ low 1 boundary after REQ; GNT=0001 on the BA boundary; BUSY=1 throughout.
  - Drop REQ after 5 cycles: GNT=0 and nDMABREQ=1 on the same edge.
- Burst cap: REQ=0100 held permanently.
  - Required: GNT high exactly 14 boundaries, then release.
  - After BA=0, one idle boundary, then nDMABREQ low again with OWNER=2.
- Round robin: REQ=1011 held permanently.
  - Required: grant order is 0, 1, 3, 0, 1, 3.
  - OWNER matches each grant; GNT is never multi-hot.
- Withdrawal in WAIT_BA: REQ=0010 sampled, then REQ=0000 while BA=0.
  - Required: nDMABREQ returns high, GNT stays 0, state goes RELEASE then IDLE.
  - `last` is unchanged: the next REQ=0011 grants master 0 first.
- Reset mid-grant: assert nRESET low in the 7th GRANT cycle.
  - Required: GNT=0, nDMABREQ=1, BUSY=0, OWNER=0 immediately, with no clock edge.
  - After reset, REQ=1000 arbitration grants master 3.
- Boundary gating: pulse REQ=0001 for 1 CLK between CE_E_FALL strobes.
  - Required: no nDMABREQ assertion; all outputs remain at reset values.

Source files
------------

// File: rtl/mc6809_dma_arbiter.sv
// Round-robin DMA bus arbiter for the MC6809: requests the bus via nDMABREQ, grants one master per burst.
// Decisions are registered on E-fall boundaries (1 boundary REQ->nDMABREQ); bursts are capped at MAX_BURST cycles.
module mc6809_dma_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 14
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  input  logic                    CE_E_FALL,
  input  logic [NREQ-1:0]         REQ,
  input  logic                    BA,
  input  logic                    BS,
  output logic                    nDMABREQ,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    BUSY
);

  localparam int OW = $clog2(NREQ);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BA,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            ndmabreq_q, ndmabreq_d;

  logic [OW-1:0]   rr_winner;
  logic            owner_req;

  // Search starts one past the last completed grant and wraps around.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [OW-1:0]   last);
    logic [OW-1:0] win;
    logic [OW-1:0] idx;
    logic          found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = OW'((int'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    rr_winner = rr_pick(REQ, last_q);
    owner_req = REQ[owner_q];
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    ndmabreq_d  = ndmabreq_q;

    if (CE_E_FALL) begin
      case (state_q)
        ST_IDLE: begin
          gnt_d      = '0;
          ndmabreq_d = 1'b1;
          if (|REQ) begin
            owner_d    = rr_winner;
            ndmabreq_d = 1'b0;
            state_d    = ST_WAIT_BA;
          end
        end

        ST_WAIT_BA: begin
          // A withdrawn request wins over a bus that just became available.
          if (!owner_req) begin
            ndmabreq_d = 1'b1;
            state_d    = ST_RELEASE;
          end else if (BA && BS) begin
            gnt_d       = NREQ'(1) << owner_q;
            burst_cnt_d = 4'd0;
            state_d     = ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (!owner_req || (burst_cnt_q == BURST_LAST)) begin
            gnt_d      = '0;
            ndmabreq_d = 1'b1;
            last_d     = owner_q;
            state_d    = ST_RELEASE;
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end

        ST_RELEASE: begin
          gnt_d      = '0;
          ndmabreq_d = 1'b1;
          if (!BA) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          gnt_d      = '0;
          ndmabreq_d = 1'b1;
          state_d    = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= OW'(NREQ - 1);
      burst_cnt_q <= 4'd0;
      gnt_q       <= '0;
      ndmabreq_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      ndmabreq_q  <= ndmabreq_d;
    end
  end

  assign nDMABREQ = ndmabreq_q;
  assign GNT      = gnt_q;
  assign OWNER    = owner_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mc6809_dma_arbiter.sv
// Directed bench for mc6809_dma_arbiter (NREQ=4, MAX_BURST=14) with immediate-assertion checks.
module tb_mc6809_dma_arbiter;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b1;
  logic       CE_E_FALL = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic       BA = 1'b0;
  logic       BS = 1'b0;
  logic       nDMABREQ;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUSY;

  int tests = 0;
  int fails = 0;

  mc6809_dma_arbiter #(.NREQ(4), .MAX_BURST(14)) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .CE_E_FALL (CE_E_FALL),
    .REQ       (REQ),
    .BA        (BA),
    .BS        (BS),
    .nDMABREQ  (nDMABREQ),
    .GNT       (GNT),
    .OWNER     (OWNER),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic nb, input logic [3:0] g,
                         input logic [1:0] own, input logic busy);
    chk({tag, ".nDMABREQ"}, 32'(nDMABREQ), 32'(nb));
    chk({tag, ".GNT"},      32'(GNT),      32'(g));
    chk({tag, ".OWNER"},    32'(OWNER),    32'(own));
    chk({tag, ".BUSY"},     32'(BUSY),     32'(busy));
  endtask

  // One bus-cycle boundary; returns 1 time unit after the strobed edge.
  task automatic boundary();
    @(negedge CLK);
    CE_E_FALL = 1'b1;
    @(posedge CLK);
    #1;
    CE_E_FALL = 1'b0;
  endtask

  // Two back-to-back strobed edges.
  task automatic boundary2();
    @(negedge CLK);
    CE_E_FALL = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    CE_E_FALL = 1'b0;
  endtask

  // From IDLE with REQ held: arbitrate, grant once BA/BS rise, run the burst to its cap.
  task automatic serve(input logic [1:0] exp_owner);
    logic [3:0] exp_gnt;
    int         len;
    exp_gnt = 4'b0001 << exp_owner;
    boundary();
    chk_out("serve.arb", 1'b0, 4'b0000, exp_owner, 1'b1);
    BA = 1'b1;
    BS = 1'b1;
    boundary();
    chk_out("serve.gnt", 1'b0, exp_gnt, exp_owner, 1'b1);
    len = 1;
    for (int i = 0; i < 20; i++) begin
      boundary();
      if (GNT === 4'b0000) break;
      len++;
      chk("serve.onehot", 32'(GNT), 32'(exp_gnt));
    end
    chk("serve.burst_len", 32'(len), 32'd14);
    chk_out("serve.rel", 1'b1, 4'b0000, exp_owner, 1'b1);
  endtask

  initial begin
    logic [1:0] rr_order [6];
    rr_order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    #1 nRESET = 1'b0;
    #2;
    chk_out("reset", 1'b1, 4'b0000, 2'd0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 nRESET = 1'b1;

    // REQ pulse that never coincides with a strobe must be invisible.
    boundary();
    REQ = 4'b0001;
    @(posedge CLK);
    #1 REQ = 4'b0000;
    boundary();
    chk_out("gating", 1'b1, 4'b0000, 2'd0, 1'b0);

    // Withdrawal while waiting for BA; last stays at 3.
    REQ = 4'b0010;
    boundary();
    chk_out("wd.arb", 1'b0, 4'b0000, 2'd1, 1'b1);
    REQ = 4'b0000;
    boundary();
    chk_out("wd.release", 1'b1, 4'b0000, 2'd1, 1'b1);
    boundary();
    chk_out("wd.idle", 1'b1, 4'b0000, 2'd1, 1'b0);
    REQ = 4'b0011;
    boundary();
    chk_out("wd.rearb", 1'b0, 4'b0000, 2'd0, 1'b1);

    // Single master 0: BA/BS arrive two boundaries after nDMABREQ falls.
    REQ = 4'b0001;
    boundary();
    chk_out("single.wait", 1'b0, 4'b0000, 2'd0, 1'b1);
    BA = 1'b1;
    BS = 1'b1;
    boundary();
    chk_out("single.gnt", 1'b0, 4'b0001, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      boundary();
      chk_out("single.hold", 1'b0, 4'b0001, 2'd0, 1'b1);
    end
    REQ = 4'b0000;
    boundary();
    chk_out("single.drop", 1'b1, 4'b0000, 2'd0, 1'b1);
    BA = 1'b0;
    BS = 1'b0;
    boundary();
    chk_out("single.idle", 1'b1, 4'b0000, 2'd0, 1'b0);

    // Burst cap with master 2 holding its request.
    REQ = 4'b0100;
    serve(2'd2);
    boundary();
    chk_out("cap.ba_held", 1'b1, 4'b0000, 2'd2, 1'b1);
    BA = 1'b0;
    BS = 1'b0;
    boundary();
    chk_out("cap.idle", 1'b1, 4'b0000, 2'd2, 1'b0);
    boundary();
    chk_out("cap.rearb", 1'b0, 4'b0000, 2'd2, 1'b1);
    REQ = 4'b0000;
    boundary();
    boundary();
    chk_out("cap.cleanup", 1'b1, 4'b0000, 2'd2, 1'b0);

    // Fresh reset so round robin starts from master 0.
    @(negedge CLK);
    nRESET = 1'b0;
    #1;
    chk_out("reset2", 1'b1, 4'b0000, 2'd0, 1'b0);
    @(posedge CLK);
    #1 nRESET = 1'b1;

    REQ = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      serve(rr_order[k]);
      BA = 1'b0;
      BS = 1'b0;
      boundary();
      chk("rr.idle", 32'(BUSY), 32'd0);
    end

    // Reset asserted in the 7th GRANT cycle of master 0 (last is 3).
    REQ = 4'b0001;
    boundary();
    chk_out("mid.arb", 1'b0, 4'b0000, 2'd0, 1'b1);
    BA = 1'b1;
    BS = 1'b1;
    boundary();
    for (int i = 0; i < 6; i++) boundary();
    chk_out("mid.grant7", 1'b0, 4'b0001, 2'd0, 1'b1);
    #1 nRESET = 1'b0;
    #1;
    chk_out("mid.reset", 1'b1, 4'b0000, 2'd0, 1'b0);
    #1 nRESET = 1'b1;
    BA = 1'b0;
    BS = 1'b0;
    REQ = 4'b1000;
    boundary();
    chk_out("post.arb", 1'b0, 4'b0000, 2'd3, 1'b1);
    BA = 1'b1;
    BS = 1'b1;
    boundary();
    chk_out("post.gnt", 1'b0, 4'b1000, 2'd3, 1'b1);

    // Back-to-back strobes: end burst then hold RELEASE while BA high; then go idle.
    REQ = 4'b0000;
    boundary2();
    chk_out("cc.release", 1'b1, 4'b0000, 2'd3, 1'b1);
    BA = 1'b0;
    BS = 1'b0;
    boundary2();
    chk_out("cc.idle", 1'b1, 4'b0000, 2'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
